// File: rtl/encoder_8b10b_tx_if.sv
// Byte-in / symbol-out bundle for the 8b10b transmit encoder.
interface encoder_8b10b_tx_if;
   logic       enable_i;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_o;
   logic [9:0] out10b_o;
   logic       out_valid_o;
   logic       training_o;

   modport master (
      output enable_i, data_i, valid_i,
      input  ready_o, out10b_o, out_valid_o, training_o
   );

   modport slave (
      input  enable_i, data_i, valid_i,
      output ready_o, out10b_o, out_valid_o, training_o
   );
endinterface

// File: rtl/encoder_8b10b_tx.sv
// 8b->10b dual-half encoder with training burst. One registered symbol per cycle.
// ready depends only on state, so upstream sees full throughput in DATA and IDLE fill in gaps.
module encoder_8b10b_tx #(
   parameter int TRAIN_LEN_P = 16
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   encoder_8b10b_tx_if.slave  bus
);
   localparam int CW = (TRAIN_LEN_P > 0) ? $clog2(TRAIN_LEN_P + 1) : 1;
   localparam logic [CW-1:0] LAST_C = CW'((TRAIN_LEN_P > 0) ? TRAIN_LEN_P - 1 : 0);
   localparam logic [9:0] IDLE_C = 10'h29A;

   typedef enum logic [1:0] {OFF, TRAIN, DATA} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [9:0]    out10b_q;
   logic          out_valid_q;
   logic [9:0]    code_d;

   function automatic logic [4:0] h3(input logic [3:0] i);
      case (i)
         4'd0: h3 = 5'b00111;  4'd1: h3 = 5'b01011;
         4'd2: h3 = 5'b01101;  4'd3: h3 = 5'b01110;
         4'd4: h3 = 5'b10011;  4'd5: h3 = 5'b10101;
         4'd6: h3 = 5'b10110;  4'd7: h3 = 5'b11001;
         4'd8: h3 = 5'b11010;  4'd9: h3 = 5'b11100;
         default: h3 = 5'b00000;
      endcase
   endfunction

   function automatic logic [4:0] h2(input logic [3:0] i);
      case (i)
         4'd0: h2 = 5'b00011;  4'd1: h2 = 5'b00101;
         4'd2: h2 = 5'b00110;  4'd3: h2 = 5'b01010;
         4'd4: h2 = 5'b01100;  4'd5: h2 = 5'b01001;
         4'd6: h2 = 5'b10001;  4'd7: h2 = 5'b10010;
         4'd8: h2 = 5'b10100;  4'd9: h2 = 5'b11000;
         default: h2 = 5'b00000;
      endcase
   endfunction

   function automatic logic [4:0] h4(input logic [2:0] i);
      case (i)
         3'd0: h4 = 5'b11110;  3'd1: h4 = 5'b11101;
         3'd2: h4 = 5'b11011;  3'd3: h4 = 5'b10111;
         3'd4: h4 = 5'b01111;
         default: h4 = 5'b00000;
      endcase
   endfunction

   function automatic logic [4:0] h1(input logic [2:0] i);
      case (i)
         3'd0: h1 = 5'b00001;  3'd1: h1 = 5'b00010;
         3'd2: h1 = 5'b00100;  3'd3: h1 = 5'b01000;
         3'd4: h1 = 5'b10000;
         default: h1 = 5'b00000;
      endcase
   endfunction

   // 00-7F use the 8x8 grids; 80-FF spend the spare H3/H2 codes and the H4/H1 pairs.
   function automatic logic [9:0] enc(input logic [7:0] b);
      logic [9:0] r;
      r = '0;
      if (!b[7]) begin
         r = b[6] ? {h2({1'b0, b[5:3]}), h3({1'b0, b[2:0]})}
                  : {h3({1'b0, b[5:3]}), h2({1'b0, b[2:0]})};
      end else begin
         case (b[6:4])
            3'd0: r = {h3({3'b100, b[3]}), h2({1'b0, b[2:0]})};
            3'd1: r = {h2({3'b100, b[3]}), h3({1'b0, b[2:0]})};
            3'd2: r = {h3({1'b0, b[2:0]}), h2({3'b100, b[3]})};
            3'd3: r = {h2({1'b0, b[2:0]}), h3({3'b100, b[3]})};
            3'd4: r = {h4({1'b0, b[3:2]}), h1({1'b0, b[1:0]})};
            3'd5: r = {h1({1'b0, b[3:2]}), h4({1'b0, b[1:0]})};
            3'd6: begin
               case (b[3:2])
                  2'd0:    r = {h4(3'd4), h1({1'b0, b[1:0]})};
                  2'd1:    r = {h1(3'd4), h4({1'b0, b[1:0]})};
                  2'd2:    r = {h4({1'b0, b[1:0]}), h1(3'd4)};
                  default: r = {h1({1'b0, b[1:0]}), h4(3'd4)};
               endcase
            end
            default: begin
               if (b[3])       r = {h3(4'd8), h3({1'b0, b[2:0]})};
               else if (!b[2]) r = {h3({3'b100, b[1]}), h2({3'b100, b[0]})};
               else if (!b[1]) r = {h2(4'd9), h3({3'b100, b[0]})};
               else if (!b[0]) r = {h4(3'd4), h1(3'd4)};
               else            r = {h1(3'd4), h4(3'd4)};
            end
         endcase
      end
      return r;
   endfunction

   always_comb begin
      code_d = enc(bus.data_i);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= OFF;
         cnt_q       <= '0;
         out10b_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            OFF: begin
               out_valid_q <= 1'b0;
               out10b_q    <= '0;
               if (bus.enable_i) state_q <= (TRAIN_LEN_P == 0) ? DATA : TRAIN;
            end
            TRAIN: begin
               out_valid_q <= 1'b1;
               out10b_q    <= IDLE_C;
               if (!bus.enable_i) begin
                  state_q <= OFF;
                  cnt_q   <= '0;
               end else if (cnt_q == LAST_C) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DATA: begin
               out_valid_q <= 1'b1;
               out10b_q    <= bus.valid_i ? code_d : IDLE_C;
               if (!bus.enable_i) state_q <= OFF;
            end
            default: state_q <= OFF;
         endcase
      end
   end

   assign bus.ready_o     = (state_q == DATA);
   assign bus.training_o  = (state_q == TRAIN);
   assign bus.out10b_o    = out10b_q;
   assign bus.out_valid_o = out_valid_q;
endmodule

// File: tb/tb_encoder_8b10b_tx.sv
// Directed bench: training burst, known vectors, full byte sweep with decode, disable, reset, zero-length training.
module tb_encoder_8b10b_tx;
   logic clk_i = 1'b0;
   logic reset_n_i = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk_i = ~clk_i;

   encoder_8b10b_tx_if b4();
   encoder_8b10b_tx_if b0();

   encoder_8b10b_tx #(.TRAIN_LEN_P(4)) u_dut4 (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(b4));
   encoder_8b10b_tx #(.TRAIN_LEN_P(0)) u_dut0 (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(b0));

   logic [4:0] t3 [10] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110, 5'b10011,
                           5'b10101, 5'b10110, 5'b11001, 5'b11010, 5'b11100};
   logic [4:0] t2 [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01100,
                           5'b01001, 5'b10001, 5'b10010, 5'b10100, 5'b11000};
   logic [4:0] t4 [5]  = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
   logic [4:0] t1 [5]  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

   logic [7:0] vec_din [9] = '{8'h00, 8'h5A, 8'h80, 8'hA5, 8'hC6, 8'hF6, 8'hFF, 8'hE5, 8'hF4};
   logic [9:0] vec_exp [9] = '{10'h0E3, 10'h14D, 10'h343, 10'h2B4, 10'h3A4, 10'h1F0, 10'h359,
                               10'h21D, 10'h31A};
   logic [9:0] codes [256];

   function automatic int half_idx(input logic [4:0] c);
      int k;
      k = $countones(c);
      for (int j = 0; j < 10; j++) begin
         if (k == 3 && t3[j] == c) return j;
         if (k == 2 && t2[j] == c) return j;
         if (j < 5 && k == 4 && t4[j] == c) return j;
         if (j < 5 && k == 1 && t1[j] == c) return j;
      end
      return -1;
   endfunction

   // Independent decoder: classify each half by weight, then map the pair back to a byte.
   function automatic int decode(input logic [9:0] s);
      int cu, cl, iu, il;
      cu = $countones(s[9:5]);
      cl = $countones(s[4:0]);
      iu = half_idx(s[9:5]);
      il = half_idx(s[4:0]);
      if (iu < 0 || il < 0) return -1;
      if (cu == 3 && cl == 2) begin
         if (iu < 8 && il < 8) return iu * 8 + il;
         if (il < 8) return 'h80 + (iu - 8) * 8 + il;
         if (iu < 8) return 'hA0 + (il - 8) * 8 + iu;
         return 'hF0 + (iu - 8) * 2 + (il - 8);
      end
      if (cu == 2 && cl == 3) begin
         if (iu < 8 && il < 8) return 'h40 + iu * 8 + il;
         if (il < 8) return 'h90 + (iu - 8) * 8 + il;
         if (iu < 8) return 'hB0 + (il - 8) * 8 + iu;
         if (iu == 9) return 'hF4 + (il - 8);
         return -1;
      end
      if (cu == 3 && cl == 3) return (iu == 8 && il < 8) ? 'hF8 + il : -1;
      if (cu == 4 && cl == 1) begin
         if (iu < 4 && il < 4) return 'hC0 + iu * 4 + il;
         if (iu == 4 && il < 4) return 'hE0 + il;
         if (iu < 4 && il == 4) return 'hE8 + iu;
         return 'hF6;
      end
      if (cu == 1 && cl == 4) begin
         if (iu < 4 && il < 4) return 'hD0 + iu * 4 + il;
         if (iu == 4 && il < 4) return 'hE4 + il;
         if (iu < 4 && il == 4) return 'hEC + iu;
         return 'hF7;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      #2 reset_n_i = 1'b0;
      #1;
      total++; if (b4.out10b_o !== 10'h000) begin bad++; $display("FAIL reset_out10b got=%h want=000", b4.out10b_o); end
      total++; if (b4.out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", b4.out_valid_o); end
      total++; if (b4.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", b4.ready_o); end
      total++; if (b4.training_o !== 1'b0) begin bad++; $display("FAIL reset_training got=%b want=0", b4.training_o); end
      total++; if (b0.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b want=0", b0.ready_o); end
      tick();
      tick();
      reset_n_i = 1'b1;
   endtask

   // Call with enable_i already high and the DUT in OFF.
   task automatic test_train(input string tag);
      tick();
      total++; if (b4.training_o !== 1'b1) begin bad++; $display("FAIL %s_train_enter got=%b want=1", tag, b4.training_o); end
      total++; if (b4.out_valid_o !== 1'b0) begin bad++; $display("FAIL %s_train_first_valid got=%b want=0", tag, b4.out_valid_o); end
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++; if (b4.out10b_o !== 10'h29A || b4.out_valid_o !== 1'b1) begin
            bad++; $display("FAIL %s_train_idle[%0d] got=%h/%b want=29A/1", tag, i, b4.out10b_o, b4.out_valid_o);
         end
         total++; if (b4.ready_o !== (i == 4) || b4.training_o !== (i != 4)) begin
            bad++; $display("FAIL %s_train_flags[%0d] got rdy=%b trn=%b want rdy=%b trn=%b",
                            tag, i, b4.ready_o, b4.training_o, i == 4, i != 4);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 9; i++) begin
         b4.valid_i = 1'b1;
         b4.data_i  = vec_din[i];
         tick();
         total++; if (b4.out10b_o !== vec_exp[i] || b4.out_valid_o !== 1'b1) begin
            bad++; $display("FAIL b2b[%h] got=%h/%b want=%h/1", vec_din[i], b4.out10b_o, b4.out_valid_o, vec_exp[i]);
         end
      end
      b4.valid_i = 1'b0;
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 4; i++) begin
         b4.valid_i = i[0];
         b4.data_i  = 8'h5A;
         tick();
         total++; if (b4.out10b_o !== (i[0] ? 10'h14D : 10'h29A)) begin
            bad++; $display("FAIL gap[%0d] got=%h want=%h", i, b4.out10b_o, i[0] ? 10'h14D : 10'h29A);
         end
      end
      b4.valid_i = 1'b0;
   endtask

   task automatic test_all_bytes();
      int dup;
      for (int i = 0; i < 256; i++) begin
         b4.valid_i = 1'b1;
         b4.data_i  = i[7:0];
         tick();
         codes[i] = b4.out10b_o;
         total++; if (codes[i] === 10'h29A || b4.out_valid_o !== 1'b1) begin
            bad++; $display("FAIL sweep_idle[%h] got=%h/%b want non-29A/1", i[7:0], codes[i], b4.out_valid_o);
         end
         total++; if (decode(codes[i]) !== i) begin
            bad++; $display("FAIL sweep_decode[%h] code=%h got=%0d want=%0d", i[7:0], codes[i], decode(codes[i]), i);
         end
      end
      b4.valid_i = 1'b0;
      for (int i = 1; i < 256; i++) begin
         dup = -1;
         for (int j = 0; j < i; j++) if (codes[j] === codes[i]) dup = j;
         total++; if (dup !== -1) begin
            bad++; $display("FAIL sweep_distinct[%h] got=dup of %0d want=unique", i[7:0], dup);
         end
      end
   endtask

   task automatic test_disable();
      b4.valid_i  = 1'b1;
      b4.data_i   = 8'h5A;
      b4.enable_i = 1'b0;
      total++; if (b4.ready_o !== 1'b1) begin bad++; $display("FAIL dis_ready_before got=%b want=1", b4.ready_o); end
      tick();
      b4.valid_i = 1'b0;
      total++; if (b4.out10b_o !== 10'h14D || b4.out_valid_o !== 1'b1) begin
         bad++; $display("FAIL dis_last got=%h/%b want=14D/1", b4.out10b_o, b4.out_valid_o);
      end
      total++; if (b4.ready_o !== 1'b0) begin bad++; $display("FAIL dis_ready_after got=%b want=0", b4.ready_o); end
      tick();
      total++; if (b4.out_valid_o !== 1'b0 || b4.out10b_o !== 10'h000) begin
         bad++; $display("FAIL dis_drop got=%h/%b want=000/0", b4.out10b_o, b4.out_valid_o);
      end
   endtask

   task automatic test_mid_reset();
      b4.enable_i = 1'b1;
      tick();
      tick();
      tick();
      reset_n_i = 1'b0;
      #1;
      total++; if ({b4.out10b_o, b4.out_valid_o, b4.ready_o, b4.training_o} !== 13'h0) begin
         bad++; $display("FAIL rst_train got=%h/%b/%b/%b want all 0", b4.out10b_o, b4.out_valid_o, b4.ready_o, b4.training_o);
      end
      #1 reset_n_i = 1'b1;
      test_train("rearm1");
      b4.valid_i = 1'b1;
      b4.data_i  = 8'h00;
      tick();
      total++; if (b4.out10b_o !== 10'h0E3) begin bad++; $display("FAIL rst_data_pre got=%h want=0E3", b4.out10b_o); end
      reset_n_i = 1'b0;
      #1;
      total++; if ({b4.out10b_o, b4.out_valid_o, b4.ready_o, b4.training_o} !== 13'h0) begin
         bad++; $display("FAIL rst_data got=%h/%b/%b/%b want all 0", b4.out10b_o, b4.out_valid_o, b4.ready_o, b4.training_o);
      end
      b4.valid_i = 1'b0;
      #1 reset_n_i = 1'b1;
      test_train("rearm2");
   endtask

   task automatic test_zero_train();
      b0.enable_i = 1'b1;
      tick();
      total++; if (b0.ready_o !== 1'b1 || b0.training_o !== 1'b0) begin
         bad++; $display("FAIL zt_ready got rdy=%b trn=%b want 1/0", b0.ready_o, b0.training_o);
      end
      total++; if (b0.out_valid_o !== 1'b0) begin bad++; $display("FAIL zt_no_idle got=%b want=0", b0.out_valid_o); end
      b0.valid_i = 1'b1;
      b0.data_i  = 8'hFF;
      tick();
      total++; if (b0.out10b_o !== 10'h359 || b0.out_valid_o !== 1'b1) begin
         bad++; $display("FAIL zt_first got=%h/%b want=359/1", b0.out10b_o, b0.out_valid_o);
      end
      b0.valid_i = 1'b0;
   endtask

   initial begin
      b4.enable_i = 1'b0; b4.valid_i = 1'b0; b4.data_i = 8'h00;
      b0.enable_i = 1'b0; b0.valid_i = 1'b0; b0.data_i = 8'h00;
      test_reset();
      b4.enable_i = 1'b1;
      test_train("first");
      test_back_to_back();
      test_gaps();
      test_all_bytes();
      test_disable();
      test_mid_reset();
      test_zero_train();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
